// File: rtl/aes_inv_main.sv
// Iterative AES-128 decryptor: the forward key schedule is replayed to rk10, then one
// InvCipher round per cycle while the schedule is walked back to rk0.
package aes_gf_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0 as AES requires
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
endpackage

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] v;
  always_comb begin
    v = ginv(a);
    y = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  end
endmodule

module aes_inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import aes_gf_pkg::*;
  logic [7:0] u;
  always_comb begin
    u = {a[1:0], a[7:2]} ^ {a[4:0], a[7:5]} ^ {a[6:0], a[7]} ^ 8'h05;
    y = ginv(u);
  end
endmodule

module aes_inv_main (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] i_block,
  input  logic [127:0] init_key,
  output logic [127:0] o_block,
  output logic         block_finish,
  output logic         busy
);
  import aes_gf_pkg::*;

  typedef enum logic [2:0] {IDLE = 3'd0, KEXP = 3'd1, INIT = 3'd2, ROUND = 3'd3, DONE = 3'd4} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] key_q, key_d, blk_q, blk_d, out_q, out_d;
  logic [31:0]  w0, w1, w2, w3, sw_in, sw_rot, sw_out, fw0, fw1, fw2, fw3;
  logic [7:0]   rc;
  logic [127:0] rk_fwd, rk_inv, isr, isb, ark;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Row r of the column-major state rotates right by r columns
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // One SubWord serves both directions: forward uses w3, inverse uses the recovered w3'
  always_comb begin
    sw_in  = (state_q == ROUND) ? (w3 ^ w2) : w3;
    rc     = rcon((state_q == ROUND) ? (cnt_q + 4'd1) : cnt_q);
    sw_rot = {sw_in[23:0], sw_in[31:24]};
    fw0    = w0 ^ sw_out ^ {rc, 24'h0};
    fw1    = w1 ^ fw0;
    fw2    = w2 ^ fw1;
    fw3    = w3 ^ fw2;
    rk_fwd = {fw0, fw1, fw2, fw3};
    rk_inv = {fw0, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    isr    = inv_shift_rows(blk_q);
    ark    = isb ^ rk_inv;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sub_word
    aes_sbox u_sbox (.a(sw_rot[8*g +: 8]), .y(sw_out[8*g +: 8]));
  end

  for (genvar b = 0; b < 16; b++) begin : g_inv_sub
    aes_inv_sbox u_inv_sbox (.a(isr[127-8*b -: 8]), .y(isb[127-8*b -: 8]));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    blk_d   = blk_q;
    out_d   = out_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          blk_d   = i_block;
          key_d   = init_key;
          cnt_d   = 4'd1;
          state_d = KEXP;
        end
      end
      KEXP: begin
        key_d = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd10) state_d = INIT;
      end
      INIT: begin
        blk_d   = blk_q ^ key_q;
        cnt_d   = 4'd9;
        state_d = ROUND;
      end
      ROUND: begin
        key_d = rk_inv;
        if (cnt_q != 4'd0) begin
          blk_d = inv_mix_columns(ark);
          cnt_d = cnt_q - 4'd1;
        end else begin
          blk_d   = ark;
          out_d   = ark;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      key_q   <= '0;
      blk_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      blk_q   <= blk_d;
      out_q   <= out_d;
    end
  end

  assign o_block      = out_q;
  assign block_finish = (state_q == DONE);
  assign busy         = (state_q == KEXP) || (state_q == INIT) || (state_q == ROUND);
endmodule

// File: doc/aes_inv_main.md
AES_INV_MAIN -- requirements
Module: aes_inv_main

Interface
REQ-001 Parameters: none; fixed AES-128 (Nk=4, Nr=10).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to decrypt; sampled only in IDLE.
REQ-005 i_block  input  128  ciphertext; sampled with accepted start.
REQ-006 init_key  input  128  cipher key (round key 0); sampled with accepted start.
REQ-007 o_block  output  128  plaintext; valid from block_finish until the next accepted start.
REQ-008 block_finish  output  1  one-cycle pulse; o_block holds a new plaintext.
REQ-009 busy  output  1  high from the accepted start until block_finish; start is ignored while busy.

Function
REQ-010 The block SHALL implement FIPS-197 InvCipher; bit 127 is byte 0; the state is column-major (bytes 0-3 = column 0).
REQ-011 The FSM states SHALL be IDLE, KEXP, INIT, ROUND, DONE.
REQ-012 IDLE: when start=1 at an edge, the block SHALL latch i_block and init_key, set round counter=1, and go to KEXP.
REQ-013 KEXP: each cycle, the block SHALL apply one forward key-expansion step (RotWord, SubWord, Rcon[counter]) to the key register and increment the counter; after 10 cycles the key register SHALL hold round key 10, then go to INIT.
REQ-014 INIT: state <= block XOR rk10; counter <= 9; go to ROUND.
REQ-015 ROUND: each cycle, the block SHALL derive rk(counter) from rk(counter+1) by inverse key schedule:
- w3' = w3^w2
- w2' = w2^w1
- w1' = w1^w0
- w0' = w0^SubWord(RotWord(w3'))^Rcon[counter+1]
REQ-016 ROUND, counter 9..1: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk(counter))); counter decrements.
REQ-017 ROUND, counter 0: state <= AddRoundKey(InvSubBytes(InvShiftRows(state)), rk0), with no InvMixColumns; go to DONE.
REQ-018 The final rk0 SHALL equal the latched init_key; this is an internal assertion target.
REQ-019 DONE: o_block <= state; block_finish=1 for exactly this cycle; busy=0; then go to IDLE.
REQ-020 Latency: with start accepted at edge E, block_finish SHALL be high in the cycle after edge E+21 (10 KEXP + 1 INIT + 10 ROUND cycles). A new start is accepted back-to-back in that same cycle.
REQ-021 While not in IDLE, changes on start, i_block or init_key SHALL have no effect.
REQ-022 Rcon SHALL run 01,02,04,08,10,20,40,80,1b,36 for indices 1..10.
REQ-023 GF(2^8) arithmetic SHALL use the AES polynomial x^8+x^4+x^3+x+1.
REQ-024 InvMixColumns coefficients SHALL be 0e, 0b, 0d, 09.
REQ-025 The forward and inverse S-box SHALL be existing codebase submodules; 4 forward instances for SubWord and 16 inverse instances for InvSubBytes.

Reset
REQ-026 Reset asserted SHALL immediately force the following, without waiting for clk:
- FSM to IDLE
- counter, key and state registers to 0
- o_block to 0
- block_finish to 0
- busy to 0
REQ-027 Reset mid-operation SHALL abort the block, with no block_finish pulse; the first start after reset deasserts SHALL begin a fresh decryption.
REQ-028 When reset and start are both high, reset SHALL win and start is not accepted.

Verification
REQ-029 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, i_block 3925841d02dc09fbdc118597196a0b32 -> o_block 3243f6a8885a308d313198a2e0370734, block_finish 21 cycles after start.
REQ-030 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, i_block 69c4e0d86a7b0430d8cdb78070b4c55a -> o_block 00112233445566778899aabbccddeeff.
REQ-031 Round-trip with the existing encryptor: key 11111111222222223333333344444444, plaintext 10101010202020203030303040404040, encryptor output fed to i_block -> o_block 10101010202020203030303040404040.
REQ-032 Start pulsed and i_block/init_key changed at cycles 5 and 15 of a run -> the result still matches REQ-029, busy stays high, and no extra block_finish occurs.
REQ-033 Reset asserted at cycle 12 of a run -> outputs are 0 asynchronously and no block_finish pulse; a restart with the App. B vector yields the App. B plaintext.
REQ-034 Two back-to-back starts (App. B, then App. C.1), the second in the block_finish cycle -> two correct results 21 cycles apart.
